// File: rtl/exec_div_seq.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU/REM/REMU in the execute stage.
// One operation per accepted start; result held until the next accepted start.
module exec_div_seq #(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            flush,
  input  logic            op_signed,
  input  logic            op_rem,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            stall_req,
  output logic            done,
  output logic [XLEN-1:0] result
);

  typedef enum logic [2:0] {S_IDLE, S_PREP, S_CALC, S_FIX, S_DONE} state_t;

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [XLEN-1:0]   r_a, r_b, r_quo, r_rem, r_div, r_result;
  logic              r_signed, r_op_rem, r_qneg, r_rneg, r_done;

  logic [XLEN-1:0]   w_abs_a, w_abs_b, w_quo_fix, w_rem_fix;
  logic [XLEN:0]     w_shift, w_diff;
  logic              w_borrow, w_ovf;

  assign w_abs_a   = (r_signed && r_a[XLEN-1]) ? -r_a : r_a;
  assign w_abs_b   = (r_signed && r_b[XLEN-1]) ? -r_b : r_b;
  assign w_ovf     = r_signed && (r_a == MIN_NEG) && (r_b == '1);

  // Partial remainder is always below the divisor, so XLEN+1 bits hold the
  // shifted value and the top bit of the difference is the borrow.
  assign w_shift   = {r_rem, r_quo[XLEN-1]};
  assign w_diff    = w_shift - {1'b0, r_div};
  assign w_borrow  = w_diff[XLEN];

  assign w_quo_fix = r_qneg ? -r_quo : r_quo;
  assign w_rem_fix = r_rneg ? -r_rem : r_rem;

  assign busy      = (r_state == S_PREP) || (r_state == S_CALC) || (r_state == S_FIX);
  assign stall_req = (start && ((r_state == S_IDLE) || (r_state == S_DONE)) && !flush) || busy;
  assign done      = r_done;
  assign result    = r_result;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_quo    <= '0;
      r_rem    <= '0;
      r_div    <= '0;
      r_result <= '0;
      r_signed <= 1'b0;
      r_op_rem <= 1'b0;
      r_qneg   <= 1'b0;
      r_rneg   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (flush) begin
        r_state <= S_IDLE;
      end else begin
        case (r_state)
          S_IDLE, S_DONE: begin
            if (start) begin
              r_a      <= a;
              r_b      <= b;
              r_signed <= op_signed;
              r_op_rem <= op_rem;
              r_state  <= S_PREP;
            end else begin
              r_state  <= S_IDLE;
            end
          end
          S_PREP: begin
            if (r_b == '0) begin
              r_result <= r_op_rem ? r_a : '1;
              r_done   <= 1'b1;
              r_state  <= S_DONE;
            end else if (w_ovf) begin
              r_result <= r_op_rem ? '0 : r_a;
              r_done   <= 1'b1;
              r_state  <= S_DONE;
            end else begin
              r_quo   <= w_abs_a;
              r_div   <= w_abs_b;
              r_rem   <= '0;
              r_qneg  <= r_signed && (r_a[XLEN-1] ^ r_b[XLEN-1]);
              r_rneg  <= r_signed && r_a[XLEN-1];
              r_cnt   <= CNT_W'(XLEN);
              r_state <= S_CALC;
            end
          end
          S_CALC: begin
            r_rem <= w_borrow ? w_shift[XLEN-1:0] : w_diff[XLEN-1:0];
            r_quo <= {r_quo[XLEN-2:0], ~w_borrow};
            r_cnt <= r_cnt - CNT_W'(1);
            if (r_cnt == CNT_W'(1)) r_state <= S_FIX;
          end
          S_FIX: begin
            r_result <= r_op_rem ? w_rem_fix : w_quo_fix;
            r_done   <= 1'b1;
            r_state  <= S_DONE;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_exec_div_seq.sv
// Directed bench for exec_div_seq: vector table for single operations, plus
// hand-written flush, mid-operation reset and back-to-back sequences.
module tb_exec_div_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, flush, op_signed, op_rem;
  logic [31:0] a, b;
  logic        busy, stall_req, done;
  logic [31:0] result;

  int pass_cnt = 0;
  int total    = 0;
  int done_cnt = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sgn;
    logic        rem;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[14];

  exec_div_seq #(.XLEN(32), .CNT_W(6)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .flush     (flush),
    .op_signed (op_signed),
    .op_rem    (op_rem),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .stall_req (stall_req),
    .done      (done),
    .result    (result)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done) done_cnt++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    else pass_cnt++;
  endtask

  task automatic run_op(input logic [31:0] a_i, input logic [31:0] b_i, input logic s_i,
                        input logic r_i, input logic [31:0] exp, input int exp_lat);
    int   lat;
    logic stall_bad;
    @(negedge clk);
    a = a_i; b = b_i; op_signed = s_i; op_rem = r_i; start = 1'b1;
    #1 chk("stall_on_start", 32'(stall_req), 32'd1);
    @(posedge clk);
    #1 start = 1'b0;
    lat = 1;
    stall_bad = 1'b0;
    while (!done && lat <= 100) begin
      if (!stall_req) stall_bad = 1'b1;
      @(posedge clk);
      #1 lat++;
    end
    chk("latency", 32'(lat), 32'(exp_lat));
    chk("result", result, exp);
    chk("stall_while_busy", 32'(stall_bad), 32'd0);
    chk("stall_on_done", 32'(stall_req), 32'd0);
    @(posedge clk);
    #1 chk("done_one_cycle", 32'(done), 32'd0);
    chk("result_hold", result, exp);
  endtask

  initial begin
    int          lat;
    logic        saw;
    logic [31:0] prev;

    vecs[0]  = '{32'd100,      32'd7,          1'b0, 1'b0, 32'd14,         35};
    vecs[1]  = '{32'd100,      32'd7,          1'b0, 1'b1, 32'd2,          35};
    vecs[2]  = '{32'hFFFFFFF9, 32'd2,          1'b1, 1'b0, 32'hFFFFFFFD,   35};
    vecs[3]  = '{32'hFFFFFFF9, 32'd2,          1'b1, 1'b1, 32'hFFFFFFFF,   35};
    vecs[4]  = '{32'h12345678, 32'd0,          1'b0, 1'b0, 32'hFFFFFFFF,   2};
    vecs[5]  = '{32'h12345678, 32'd0,          1'b0, 1'b1, 32'h12345678,   2};
    vecs[6]  = '{32'h80000000, 32'hFFFFFFFF,   1'b1, 1'b0, 32'h80000000,   2};
    vecs[7]  = '{32'h80000000, 32'hFFFFFFFF,   1'b1, 1'b1, 32'h00000000,   2};
    vecs[8]  = '{32'd7,        32'hFFFFFFFE,   1'b1, 1'b0, 32'hFFFFFFFD,   35};
    vecs[9]  = '{32'd7,        32'hFFFFFFFE,   1'b1, 1'b1, 32'd1,          35};
    vecs[10] = '{32'hFFFFFFFF, 32'd1,          1'b0, 1'b0, 32'hFFFFFFFF,   35};
    vecs[11] = '{32'h80000000, 32'hFFFFFFFF,   1'b0, 1'b0, 32'd0,          35};
    vecs[12] = '{32'h80000000, 32'hFFFFFFFF,   1'b0, 1'b1, 32'h80000000,   35};
    vecs[13] = '{32'hFFFFFFFB, 32'd0,          1'b1, 1'b1, 32'hFFFFFFFB,   2};

    rst_n = 1'b0; start = 1'b0; flush = 1'b0; op_signed = 1'b0; op_rem = 1'b0;
    a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_stall", 32'(stall_req), 32'd0);
    @(negedge clk) rst_n = 1'b1;

    for (int i = 0; i < 14; i++)
      run_op(vecs[i].a, vecs[i].b, vecs[i].sgn, vecs[i].rem, vecs[i].exp, vecs[i].lat);

    // Flush part-way through CALC, then a fresh operation.
    prev = result;
    @(negedge clk);
    a = 32'd1000; b = 32'd7; op_signed = 1'b0; op_rem = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk) flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    chk("flush_busy", 32'(busy), 32'd0);
    chk("flush_done", 32'(done), 32'd0);
    chk("flush_result", result, prev);
    saw = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1 if (done) saw = 1'b1;
    end
    chk("flush_no_done", 32'(saw), 32'd0);
    run_op(32'd50, 32'd5, 1'b0, 1'b0, 32'd10, 35);

    // Asynchronous reset in the middle of CALC.
    @(negedge clk);
    a = 32'd1000; b = 32'd7; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (6) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_result", result, 32'd0);
    chk("midrst_stall", 32'(stall_req), 32'd0);
    @(negedge clk) rst_n = 1'b1;

    // Back-to-back: second start issued during the DONE cycle of the first.
    done_cnt = 0;
    @(negedge clk);
    a = 32'd1000; b = 32'd10; op_signed = 1'b0; op_rem = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat = 1;
    while (!done && lat <= 100) begin
      @(posedge clk);
      #1 lat++;
    end
    chk("b2b_lat1", 32'(lat), 32'd35);
    chk("b2b_res1", result, 32'd100);
    a = 32'd81; b = 32'd9; start = 1'b1;
    #1;
    chk("b2b_stall", 32'(stall_req), 32'd1);
    chk("b2b_done_held", 32'(done), 32'd1);
    @(posedge clk);
    #1 start = 1'b0;
    chk("b2b_res_hold", result, 32'd100);
    lat = 1;
    while (!done && lat <= 100) begin
      @(posedge clk);
      #1 lat++;
    end
    chk("b2b_lat2", 32'(lat), 32'd35);
    chk("b2b_res2", result, 32'd9);
    repeat (4) @(posedge clk);
    #1 chk("b2b_done_pulses", 32'(done_cnt), 32'd2);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
